// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: assembles HEADER/cmd/len/payload/checksum frames
// from a UART byte stream and reports good frames or errors.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   rx_data, rx_done    received byte and its one-cycle strobe
//   frame_valid         one-cycle pulse, good frame captured
//   frame_cmd/len       command and payload length of last good frame
//   frame_payload       payload, byte k at [8k+7:8k], unused bytes zero
//   frame_err           one-cycle pulse, frame rejected
//   err_code            last error: 1 checksum, 2 length, 3 timeout
//   busy                high while a frame is in progress
//
// Optional feature (macro FRAME_ERR_CNT_EN):
//   err_cnt_clr         synchronous clear of the error counter
//   err_cnt             saturating count of frame_err pulses
module uart_rx_frame_parser #(
    parameter int         SYS_CLK_FRP   = 50_000_000,
    parameter int         BAUDRATE      = 9600,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         MAX_LEN       = 8,
    parameter int         TIMEOUT_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        frame_valid,
    output logic [7:0]  frame_cmd,
    output logic [3:0]  frame_len,
    output logic [63:0] frame_payload,
    output logic        frame_err,
    output logic [1:0]  err_code,
`ifdef FRAME_ERR_CNT_EN
    input  logic        err_cnt_clr,
    output logic [7:0]  err_cnt,
`endif
    output logic        busy
);

    localparam int TIMEOUT_CYCLES =
        (SYS_CLK_FRP / BAUDRATE) * 10 * TIMEOUT_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
        S_SUM
    } state_t;

    state_t         state_q;
    logic [7:0]     cmd_q;
    logic [7:0]     acc_q;
    logic [3:0]     len_q;
    logic [2:0]     idx_q;
    logic [63:0]    buf_q;
    logic [TW-1:0]  tmo_q;

    logic [7:0]     acc_d;
    logic           tmo_hit_d;
    logic           last_d;

    assign acc_d = acc_q + rx_data;

    // A byte arriving on the terminal cycle cancels the timeout.
    assign tmo_hit_d = (state_q != S_IDLE) && !rx_done
                    && (tmo_q == TMO_LAST);

    assign last_d = ({1'b0, idx_q} == (len_q - 4'd1));

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            acc_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            buf_q         <= '0;
            tmo_q         <= '0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            frame_err     <= 1'b0;
            err_code      <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (state_q == S_IDLE || rx_done) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (tmo_hit_d) begin
                frame_err <= 1'b1;
                err_code  <= 2'd3;
                state_q   <= S_IDLE;
                tmo_q     <= '0;
            end else if (rx_done) begin
                unique case (state_q)
                    S_IDLE: begin
                        // Non-header bytes outside a frame are dropped.
                        if (rx_data == HEADER) begin
                            acc_q   <= '0;
                            buf_q   <= '0;
                            state_q <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        cmd_q   <= rx_data;
                        acc_q   <= rx_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd2;
                            state_q   <= S_IDLE;
                        end else begin
                            acc_q   <= acc_d;
                            len_q   <= rx_data[3:0];
                            idx_q   <= '0;
                            state_q <= (rx_data == 8'd0) ? S_SUM : S_DATA;
                        end
                    end
                    S_DATA: begin
                        buf_q[{idx_q, 3'b000} +: 8] <= rx_data;
                        acc_q <= acc_d;
                        idx_q <= idx_q + 3'd1;
                        if (last_d) begin
                            state_q <= S_SUM;
                        end
                    end
                    S_SUM: begin
                        if (rx_data == acc_q) begin
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_q;
                            frame_len     <= len_q;
                            frame_payload <= buf_q;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FRAME_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    assign err_cnt = err_cnt_q;

    // Counts registered frame_err pulses; clear still counts a
    // coincident pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_cnt_clr) begin
            err_cnt_q <= frame_err ? 8'd1 : 8'd0;
        end else if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: directed and randomized frames checked
// against a frame-level model of the parser.
module tb_uart_rx_frame_parser;

    localparam int         SYS  = 1000;
    localparam int         BAUD = 100;
    localparam int         TB   = 3;
    localparam int         MAXL = 8;
    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         T    = (SYS / BAUD) * 10 * TB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic [3:0]  frame_len;
    logic [63:0] frame_payload;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
`ifdef FRAME_ERR_CNT_EN
    logic        err_cnt_clr = 1'b0;
    logic [7:0]  err_cnt;
`endif

    uart_rx_frame_parser #(
        .SYS_CLK_FRP  (SYS),
        .BAUDRATE     (BAUD),
        .HEADER       (HDR),
        .MAX_LEN      (MAXL),
        .TIMEOUT_BYTES(TB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .frame_valid  (frame_valid),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .frame_payload(frame_payload),
        .frame_err    (frame_err),
        .err_code     (err_code),
`ifdef FRAME_ERR_CNT_EN
        .err_cnt_clr  (err_cnt_clr),
        .err_cnt      (err_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model of the held outputs and pulse totals.
    logic [7:0]  m_cmd = '0;
    logic [3:0]  m_len = '0;
    logic [63:0] m_pl  = '0;
    logic [1:0]  m_code = '0;
    int nv_exp = 0;
    int ne_exp = 0;

    int nv_seen = 0;
    int ne_seen = 0;
    int both_seen = 0;

    always @(negedge clk) begin
        if (frame_valid) nv_seen++;
        if (frame_err) ne_seen++;
        if (frame_valid && frame_err) both_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) send_byte(q[i], $urandom_range(0, maxgap));
    endtask

    task automatic check_frame(input string tag, input logic ev,
                               input logic ee);
        check({tag, "_v"}, frame_valid, ev);
        check({tag, "_e"}, frame_err, ee);
        check({tag, "_cmd"}, frame_cmd, m_cmd);
        check({tag, "_len"}, frame_len, m_len);
        check({tag, "_pl"}, frame_payload, m_pl);
        check({tag, "_code"}, err_code, m_code);
        check({tag, "_busy"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {frame_valid, frame_err}, 2'b00);
    endtask

    // kind 0 good, 1 bad checksum, 2 bad length
    task automatic run_frame(input int kind);
        logic [7:0]  q[$];
        logic [7:0]  cmd, len, b, s;
        logic [63:0] pl;
        int          sum;
        q   = {};
        cmd = 8'($urandom);
        q.push_back(HDR);
        q.push_back(cmd);
        pl  = '0;
        if (kind == 2) begin
            len = 8'($urandom_range(MAXL + 1, 255));
            q.push_back(len);
        end else begin
            len = 8'($urandom_range(0, MAXL));
            q.push_back(len);
            sum = int'(cmd) + int'(len);
            for (int k = 0; k < int'(len); k++) begin
                b = 8'($urandom);
                pl[8*k +: 8] = b;
                sum += int'(b);
                q.push_back(b);
            end
            s = 8'(sum % 256);
            if (kind == 1) s = s + 8'($urandom_range(1, 255));
            q.push_back(s);
        end
        send_q(q, 3);
        if (kind == 0) begin
            m_cmd = cmd;
            m_len = len[3:0];
            m_pl  = pl;
            nv_exp++;
        end else begin
            m_code = (kind == 1) ? 2'd1 : 2'd2;
            ne_exp++;
        end
        check_frame($sformatf("rnd%0d", kind), kind == 0, kind != 0);
    endtask

    task automatic model_reset();
        m_cmd  = '0;
        m_len  = '0;
        m_pl   = '0;
        m_code = '0;
    endtask

    initial begin
        int cyc;
        int ne0;
        logic [7:0] n;

        #23;
        check("rst_state",
              {frame_valid, frame_err, frame_cmd, frame_len,
               err_code, busy}, '0);
        check("rst_pl", frame_payload, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good frame with two payload bytes.
        send_q('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h36}, 2);
        m_cmd = 8'h01;
        m_len = 4'd2;
        m_pl  = 64'h0000_0000_0000_2211;
        nv_exp++;
        check_frame("good1", 1'b1, 1'b0);

        // Same frame with a bad checksum: outputs hold.
        send_q('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h37}, 2);
        m_code = 2'd1;
        ne_exp++;
        check_frame("badsum", 1'b0, 1'b1);

        // Over-long length, then zero-length frame.
        send_q('{8'hA5, 8'h03, 8'h09}, 2);
        m_code = 2'd2;
        ne_exp++;
        check_frame("badlen", 1'b0, 1'b1);
        send_q('{8'hA5, 8'h07, 8'h00, 8'h07}, 2);
        m_cmd = 8'h07;
        m_len = 4'd0;
        m_pl  = '0;
        nv_exp++;
        check_frame("len0", 1'b1, 1'b0);

        // Timeout after cmd byte.
        send_q('{8'hA5, 8'h01}, 0);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!frame_err && cyc < T + 10);
        check("tmo_lat", cyc, T);
        check("tmo_code", err_code, 2'd3);
        check("tmo_busy", busy, 1'b0);
        m_code = 2'd3;
        ne_exp++;
        @(posedge clk);
        #1;

        // Byte lands on the terminal cycle: no timeout.
        ne0 = ne_seen;
        send_q('{8'hA5, 8'h01}, 0);
        send_byte(8'h00, T - 1);
        send_byte(8'h01, 0);
        m_cmd = 8'h01;
        m_len = 4'd0;
        m_pl  = '0;
        nv_exp++;
        check_frame("tmo_edge", 1'b1, 1'b0);
        check("tmo_edge_noerr", ne_seen, ne0);

        // Noise bytes in idle, then a good frame.
        ne0 = ne_seen;
        send_q('{8'h00, 8'hFF, 8'h5A}, 2);
        check("noise_busy", busy, 1'b0);
        send_q('{8'hA5, 8'h02, 8'h01, 8'hAA, 8'hAD}, 2);
        m_cmd = 8'h02;
        m_len = 4'd1;
        m_pl  = 64'hAA;
        nv_exp++;
        check_frame("noise", 1'b1, 1'b0);
        check("noise_noerr", ne_seen, ne0);

        // Asynchronous reset mid-payload.
        send_q('{8'hA5, 8'h01, 8'h04, 8'h11}, 1);
        #2;
        rst_n = 1'b0;
        #3;
        model_reset();
        check("midrst",
              {frame_valid, frame_err, frame_cmd, frame_len,
               err_code, busy}, '0);
        check("midrst_pl", frame_payload, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0);

        // Randomized mix of frames with idle noise between them.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = 8'($urandom);
                if (n == HDR) n = 8'h5A;
                send_byte(n, $urandom_range(0, 3));
            end
            run_frame($urandom_range(0, 2));
        end

`ifdef FRAME_ERR_CNT_EN
        rst_n = 1'b0;
        #3;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("cnt_rst", err_cnt, 8'd0);
        for (int i = 0; i < 300; i++) begin
            send_q('{8'hA5, 8'h00, 8'h09}, 0);
            ne_exp++;
        end
        @(posedge clk);
        #1;
        check("cnt_sat", err_cnt, 8'hFF);
        err_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        err_cnt_clr = 1'b0;
        check("cnt_clr", err_cnt, 8'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("n_valid", nv_seen, nv_exp);
        check("n_err", ne_seen, ne_exp);
        check("no_both", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
